// File: rtl/sc_match_pkg.sv
// sc_match_pkg: shared constants and queue-entry layout for the note-match
// scoring path. Consumers of the match queue reuse match_entry_t to unpack
// {ch, dt} words coming off the FIFO.
//   N_CH_DEF    default number of note channels
//   TW_DEF      default song-time / dt width
//   CH_W_DEF    channel index width for the default channel count
//   ENTRY_W_DEF width of one packed {ch, dt} entry
package sc_match_pkg;

  localparam int N_CH_DEF    = 37;
  localparam int TW_DEF      = 16;
  localparam int CH_W_DEF    = $clog2(N_CH_DEF);
  localparam int ENTRY_W_DEF = CH_W_DEF + TW_DEF;

  // Channel in the upper bits, signed dt in the lower bits.
  typedef struct packed {
    logic [CH_W_DEF-1:0]      ch;
    logic signed [TW_DEF-1:0] dt;
  } match_entry_t;

endpackage

// File: rtl/sc_match_fifo.sv
// sc_match_fifo: first-word-fall-through FIFO for scored match entries.
//   clk, rst   clock and synchronous active-high reset
//   push       write push_data (accepted when not full, or full with pop)
//   push_data  entry to enqueue
//   pop        remove the head entry (ignored when empty)
//   rd_data    head entry, zero while empty
//   valid      FIFO holds at least one entry
//   full       FIFO holds DEPTH entries
//   count      number of entries held
module sc_match_fifo
  import sc_match_pkg::*;
#(
  parameter  int W     = ENTRY_W_DEF,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  rd_data,
  output logic          valid,
  output logic          full,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign valid   = (count_q != '0);
  assign full    = (count_q == CW'(DEPTH));
  assign count   = count_q;
  // Head is gated so an empty FIFO presents all-zero data.
  assign rd_data = valid ? mem_q[rd_ptr_q] : '0;

  assign do_pop  = pop && valid;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: nothing is readable until count is non-zero.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/sc_match_queue.sv
// sc_match_queue: captures per-channel note-match strobes, scores each one as
// a saturated signed dt = song_time - match_time, and funnels them through a
// round-robin arbiter into an output FIFO.
//   clk, rst       clock and synchronous active-high reset
//   song_time      current song time
//   match_trigger  per-channel one-cycle match strobe
//   match_time     per-channel note time, channel i at [i*TW +: TW]
//   out_valid      FIFO head holds a scored match
//   out_ready      consumer accepts the head entry
//   out_dt, out_ch signed dt and channel of the head entry
//   fifo_level     entries held in the output FIFO
//   drop_count     saturating count of lost matches
//   overflow       sticky flag, at least one match lost
//   clear_stats    zeroes drop_count and overflow
//
// Output handshake: an entry transfers on a rising edge where out_valid and
// out_ready are both high; while out_valid is high and out_ready is low the
// head entry (out_dt, out_ch) stays unchanged.
module sc_match_queue
  import sc_match_pkg::*;
#(
  parameter  int N_CH  = N_CH_DEF,
  parameter  int TW    = TW_DEF,
  parameter  int DEPTH = 8,
  parameter  int CNT_W = 8,
  localparam int CH_W  = $clog2(N_CH),
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [TW-1:0]      song_time,
  input  logic [N_CH-1:0]    match_trigger,
  input  logic [N_CH*TW-1:0] match_time,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [TW-1:0]      out_dt,
  output logic [CH_W-1:0]    out_ch,
  output logic [LVL_W-1:0]   fifo_level,
  output logic [CNT_W-1:0]   drop_count,
  output logic               overflow,
  input  logic               clear_stats
);

  localparam int EW    = CH_W + TW;
  localparam int DN_W  = CH_W + 1;        // holds up to N_CH drops per cycle
  localparam int SUM_W = CNT_W + DN_W;

  // Difference in TW+1 bits; the top two bits disagree exactly when the
  // result does not fit in a TW-bit signed value.
  function automatic logic [TW-1:0] sat_dt(input logic [TW-1:0] st,
                                           input logic [TW-1:0] mt);
    logic [TW:0] diff;
    diff = {1'b0, st} - {1'b0, mt};
    if (diff[TW] != diff[TW-1]) begin
      sat_dt = diff[TW] ? {1'b1, {(TW-1){1'b0}}} : {1'b0, {(TW-1){1'b1}}};
    end else begin
      sat_dt = diff[TW-1:0];
    end
  endfunction

  function automatic logic [CH_W-1:0] rr_index(input logic [CH_W-1:0] base,
                                               input int k);
    int s;
    s = int'(base) + k;
    if (s >= N_CH) s = s - N_CH;
    return CH_W'(s);
  endfunction

  logic [N_CH-1:0]  pending_q, pending_d;
  logic [TW-1:0]    dt_q [N_CH];
  logic [TW-1:0]    dt_d [N_CH];
  logic [CH_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] drop_count_q, drop_count_d;
  logic             overflow_q, overflow_d;

  logic             grant_found, grant, pop;
  logic [CH_W-1:0]  grant_idx, cand;
  logic [DN_W-1:0]  drop_num;
  logic [SUM_W-1:0] drop_sum;
  logic             fifo_full, fifo_valid;
  logic [EW-1:0]    fifo_rd_data, push_data;

  // Round-robin search: first pending channel at or above rr_ptr, wrapping.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < N_CH; k++) begin
      cand = rr_index(rr_ptr_q, k);
      if (!grant_found && pending_q[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign pop       = fifo_valid && out_ready;
  // A full FIFO still takes a grant when the head leaves in the same cycle.
  assign grant     = grant_found && (!fifo_full || pop);
  assign push_data = {grant_idx, dt_q[grant_idx]};

  // Capture: a channel being granted this cycle frees its slot, so a new
  // strobe on it is taken as fresh pending work rather than a drop.
  always_comb begin
    pending_d = pending_q;
    dt_d      = dt_q;
    drop_num  = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (match_trigger[i]) begin
        if (!pending_q[i] || (grant && grant_idx == CH_W'(i))) begin
          pending_d[i] = 1'b1;
          dt_d[i]      = sat_dt(song_time, match_time[i*TW +: TW]);
        end else begin
          drop_num = drop_num + DN_W'(1);
        end
      end else if (grant && grant_idx == CH_W'(i)) begin
        pending_d[i] = 1'b0;
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant) begin
      rr_ptr_d = (grant_idx == CH_W'(N_CH - 1)) ? '0 : grant_idx + CH_W'(1);
    end
  end

  // Statistics: clear wins over any drop in the same cycle.
  always_comb begin
    drop_sum = SUM_W'(drop_count_q) + SUM_W'(drop_num);
    if (clear_stats) begin
      drop_count_d = '0;
      overflow_d   = 1'b0;
    end else begin
      drop_count_d = (drop_sum > SUM_W'({CNT_W{1'b1}})) ? '1 : drop_sum[CNT_W-1:0];
      overflow_d   = overflow_q | (drop_num != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q    <= '0;
      rr_ptr_q     <= '0;
      drop_count_q <= '0;
      overflow_q   <= 1'b0;
    end else begin
      pending_q    <= pending_d;
      rr_ptr_q     <= rr_ptr_d;
      drop_count_q <= drop_count_d;
      overflow_q   <= overflow_d;
    end
  end

  // dt slots are only meaningful while their pending bit is set.
  always_ff @(posedge clk) begin
    dt_q <= dt_d;
  end

  sc_match_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (grant),
    .push_data (push_data),
    .pop       (pop),
    .rd_data   (fifo_rd_data),
    .valid     (fifo_valid),
    .full      (fifo_full),
    .count     (fifo_level)
  );

  assign out_valid  = fifo_valid;
  assign out_ch     = fifo_rd_data[EW-1:TW];
  assign out_dt     = fifo_rd_data[TW-1:0];
  assign drop_count = drop_count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_sc_match_queue.sv
// Directed bench for sc_match_queue with default parameters
// (N_CH=37, TW=16, DEPTH=8, CNT_W=8).
module tb_sc_match_queue;

  localparam int N_CH = 37;
  localparam int TW   = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic [TW-1:0]      song_time;
  logic [N_CH-1:0]    match_trigger;
  logic [N_CH*TW-1:0] match_time;
  logic               out_valid;
  logic               out_ready;
  logic [TW-1:0]      out_dt;
  logic [5:0]         out_ch;
  logic [3:0]         fifo_level;
  logic [7:0]         drop_count;
  logic               overflow;
  logic               clear_stats;

  int n_checks = 0;
  int n_errors = 0;
  int order_37[9] = '{0, 1, 2, 3, 4, 5, 6, 8, 7};

  sc_match_queue dut (
    .clk           (clk),
    .rst           (rst),
    .song_time     (song_time),
    .match_trigger (match_trigger),
    .match_time    (match_time),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_dt        (out_dt),
    .out_ch        (out_ch),
    .fifo_level    (fifo_level),
    .drop_count    (drop_count),
    .overflow      (overflow),
    .clear_stats   (clear_stats)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Driver tasks: inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    match_trigger = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic trig(input int ch, input logic [TW-1:0] mt);
    match_trigger[ch]       = 1'b1;
    match_time[ch*TW +: TW] = mt;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst           = 1'b1;
    song_time     = '0;
    match_trigger = '0;
    match_time    = '0;
    out_ready     = 1'b0;
    clear_stats   = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("reset_valid", 32'(out_valid), 32'd0);
    chk("reset_level", 32'(fifo_level), 32'd0);
    chk("reset_dt", 32'(out_dt), 32'd0);
    chk("reset_ch", 32'(out_ch), 32'd0);
    chk("reset_drops", 32'(drop_count), 32'd0);
    chk("reset_ovf", 32'(overflow), 32'd0);

    // Single match, two-cycle latency, dt = 1000 - 990.
    out_ready = 1'b1;
    song_time = 16'd1000;
    trig(5, 16'd990);
    tick();
    match_trigger = '0;
    chk("lat_t1_valid", 32'(out_valid), 32'd0);
    tick();
    chk("lat_t2_valid", 32'(out_valid), 32'd1);
    chk("lat_ch", 32'(out_ch), 32'd5);
    chk("lat_dt", 32'(out_dt), 32'h000A);
    tick();
    chk("lat_t3_valid", 32'(out_valid), 32'd0);

    // Three simultaneous triggers, round-robin from 0.
    do_reset();
    song_time = 16'd50;
    trig(3, 16'd40);
    trig(20, 16'd30);
    trig(36, 16'd60);
    tick();
    match_trigger = '0;
    tick();
    chk("rr_a_ch", 32'(out_ch), 32'd3);
    chk("rr_a_dt", 32'(out_dt), 32'h000A);
    tick();
    chk("rr_b_valid", 32'(out_valid), 32'd1);
    chk("rr_b_ch", 32'(out_ch), 32'd20);
    chk("rr_b_dt", 32'(out_dt), 32'h0014);
    tick();
    chk("rr_c_valid", 32'(out_valid), 32'd1);
    chk("rr_c_ch", 32'(out_ch), 32'd36);
    chk("rr_c_dt", 32'(out_dt), 32'hFFF6);
    tick();
    chk("rr_end_valid", 32'(out_valid), 32'd0);
    chk("rr_drops", 32'(drop_count), 32'd0);

    // Saturation at both ends.
    song_time = 16'h0000;
    trig(0, 16'hFFFF);
    tick();
    match_trigger = '0;
    tick();
    chk("sat_neg_ch", 32'(out_ch), 32'd0);
    chk("sat_neg_dt", 32'(out_dt), 32'h8000);
    song_time = 16'hFFFF;
    trig(1, 16'h0000);
    tick();
    match_trigger = '0;
    tick();
    chk("sat_pos_ch", 32'(out_ch), 32'd1);
    chk("sat_pos_dt", 32'(out_dt), 32'h7FFF);
    tick();

    // Retrigger in the cycle the channel is granted: accepted, not dropped.
    song_time = 16'd200;
    trig(2, 16'd100);
    tick();
    trig(2, 16'd150);
    tick();
    match_trigger = '0;
    chk("regrant_a_ch", 32'(out_ch), 32'd2);
    chk("regrant_a_dt", 32'(out_dt), 32'h0064);
    tick();
    chk("regrant_b_valid", 32'(out_valid), 32'd1);
    chk("regrant_b_dt", 32'(out_dt), 32'h0032);
    tick();
    chk("regrant_end_valid", 32'(out_valid), 32'd0);
    chk("regrant_drops", 32'(drop_count), 32'd0);
    chk("regrant_ovf", 32'(overflow), 32'd0);

    // Ten triggers with a stalled consumer: FIFO fills, two stay pending.
    do_reset();
    out_ready = 1'b0;
    song_time = 16'd100;
    for (int i = 0; i < 10; i++) trig(i, 16'(i));
    tick();
    match_trigger = '0;
    repeat (9) tick();
    chk("fill_level", 32'(fifo_level), 32'd8);
    chk("fill_head_ch", 32'(out_ch), 32'd0);
    tick();
    chk("stall_valid", 32'(out_valid), 32'd1);
    chk("stall_ch", 32'(out_ch), 32'd0);
    chk("stall_dt", 32'(out_dt), 32'd100);
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("drain_valid_%0d", k), 32'(out_valid), 32'd1);
      chk($sformatf("drain_ch_%0d", k), 32'(out_ch), 32'(k));
      chk($sformatf("drain_dt_%0d", k), 32'(out_dt), 32'(100 - k));
      tick();
    end
    chk("drain_end_valid", 32'(out_valid), 32'd0);
    chk("drain_drops", 32'(drop_count), 32'd0);

    // Drop while pending behind a full FIFO, then clear_stats.
    do_reset();
    out_ready = 1'b0;
    song_time = 16'd500;
    for (int i = 0; i < 7; i++) trig(i, 16'd0);
    trig(8, 16'd0);
    tick();
    match_trigger = '0;
    repeat (9) tick();
    chk("drop_fill_level", 32'(fifo_level), 32'd8);
    trig(7, 16'd400);
    tick();
    match_trigger = '0;
    tick();
    chk("drop_before", 32'(drop_count), 32'd0);
    trig(7, 16'd0);
    tick();
    match_trigger = '0;
    chk("drop_count", 32'(drop_count), 32'd1);
    chk("drop_ovf", 32'(overflow), 32'd1);
    chk("drop_level", 32'(fifo_level), 32'd8);
    out_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      chk($sformatf("drop_order_ch_%0d", k), 32'(out_ch), 32'(order_37[k]));
      chk($sformatf("drop_order_dt_%0d", k), 32'(out_dt),
          (order_37[k] == 7) ? 32'h0064 : 32'h01F4);
      tick();
    end
    chk("drop_end_valid", 32'(out_valid), 32'd0);
    clear_stats = 1'b1;
    tick();
    clear_stats = 1'b0;
    chk("clear_drops", 32'(drop_count), 32'd0);
    chk("clear_ovf", 32'(overflow), 32'd0);

    // Reset with queued entries and a coinciding trigger.
    do_reset();
    out_ready = 1'b0;
    song_time = 16'd10;
    for (int i = 0; i < 4; i++) trig(i, 16'd0);
    tick();
    match_trigger = '0;
    repeat (5) tick();
    chk("mid_level", 32'(fifo_level), 32'd4);
    rst = 1'b1;
    trig(1, 16'd0);
    tick();
    rst           = 1'b0;
    match_trigger = '0;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_level", 32'(fifo_level), 32'd0);
    chk("mid_rst_dt", 32'(out_dt), 32'd0);
    chk("mid_rst_ch", 32'(out_ch), 32'd0);
    out_ready = 1'b1;
    repeat (4) tick();
    chk("mid_rst_stale_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_stale_level", 32'(fifo_level), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sc_match_queue.md
SC_MATCH_QUEUE -- requirements
Module: sc_match_queue

Interface
REQ-001 Parameter N_CH, default 37: number of note channels.
REQ-002 Parameter TW, default 16: song-time and dt width.
REQ-003 Parameter DEPTH, default 8, power of two >= 2: output FIFO entries.
REQ-004 Parameter CNT_W, default 8: drop-counter width; CH_W = clog2(N_CH).
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 song_time  in  TW  current song time, unsigned.
REQ-008 match_trigger  in  N_CH  per-channel one-cycle match strobe.
REQ-009 match_time  in  N_CH*TW  channel i note time at bits [i*TW+TW-1 : i*TW], unsigned.
REQ-010 out_valid  out  1  FIFO head holds a scored match.
REQ-011 out_ready  in  1  consumer accepts head; pop when out_valid and out_ready.
REQ-012 out_dt  out  TW  signed dt of head entry.
REQ-013 out_ch  out  CH_W  channel index of head entry.
REQ-014 fifo_level  out  clog2(DEPTH)+1  entries currently held.
REQ-015 drop_count  out  CNT_W  saturating count of lost matches.
REQ-016 overflow  out  1  sticky: at least one match lost.
REQ-017 clear_stats  in  1  zeroes drop_count and overflow.

Function
REQ-018 Capture: trigger on channel i at cycle t SHALL set pending[i] and store dt_i computed from song_time and match_time sampled at t.
REQ-019 dt SHALL be song_time - match_time in TW+1-bit signed arithmetic (both zero-extended), saturated to [-2^(TW-1), 2^(TW-1)-1].
REQ-020 Every simultaneous trigger SHALL be captured; no channel masks another.
REQ-021 Arbiter SHALL grant one pending channel per cycle, round-robin: search from rr_ptr upward with wrap; after a grant rr_ptr = (grant+1) mod N_CH.
REQ-022 Grant SHALL occur only when FIFO not full, or full with a pop in the same cycle; granted entry {ch, dt} is pushed and pending cleared.
REQ-023 Latency: trigger at t, empty FIFO, no contention -> out_valid high at t+2.
REQ-024 FIFO SHALL be first-word-fall-through; out_dt/out_ch valid whenever out_valid; order preserved.
REQ-025 Trigger on channel already pending and not granted that cycle SHALL be dropped: stored dt retained, drop_count +1 (saturating at 2^CNT_W-1), overflow set.
REQ-026 Trigger on channel granted in the same cycle SHALL be accepted as new pending with new dt; not a drop.
REQ-027 clear_stats coinciding with a drop: clear takes priority; drop_count = 0, overflow = 0.
REQ-028 Outputs SHALL be held stable while out_valid and not out_ready.

Reset
REQ-029 rst SHALL clear pending, FIFO pointers, rr_ptr, drop_count, overflow; out_valid = 0, fifo_level = 0, out_dt = 0, out_ch = 0 the cycle after.
REQ-030 Triggers coinciding with rst SHALL be ignored; rst mid-operation discards all queued and pending matches.

Structure
REQ-031 Shared package sc_match_pkg SHALL hold the default N_CH/TW constants and the {ch, dt} entry layout/width, reused by scoring consumers.
REQ-032 FIFO SHALL be one sub-module, sc_match_fifo (parametrised width/DEPTH, FWFT, count output); capture, arbiter, stats stay in the top.

Verification (N_CH=37, TW=16, DEPTH=8)
REQ-033 Trigger ch5, song_time=1000, match_time[5]=990, out_ready=1 -> two cycles later out_valid=1, out_ch=5, out_dt=+10 for one cycle.
REQ-034 Triggers ch3, ch20, ch36 same cycle, rr_ptr=0, out_ready=1 -> outputs on three consecutive cycles, ch 3, 20, 36; drop_count=0.
REQ-035 song_time=0x0000, match_time=0xFFFF -> out_dt=0x8000 (-32768); song_time=0xFFFF, match_time=0x0000 -> out_dt=0x7FFF.
REQ-036 out_ready=0, distinct triggers on ch0..ch9 -> fifo_level=8, ch8/ch9 remain pending; raise out_ready -> all 10 delivered in order 0..9, drop_count=0.
REQ-037 With ch7 pending and FIFO full, retrigger ch7 -> drop_count=1, overflow=1, original ch7 dt delivered later; pulse clear_stats -> both 0.
REQ-038 FIFO holding 4 entries, assert rst one cycle -> next cycle out_valid=0, fifo_level=0; no stale entry emitted afterwards.
